// File: rtl/video_out_load_pkg.sv
// Shared types and constants for the video-output frame loader.
package video_out_pkg;

    // Frame fetch sequencer states.
    typedef enum logic [2:0] {
        WAIT_ADDR,
        WAIT_ROOM,
        REQ,
        WAIT_ACK,
        FRAME_DONE
    } state_t;

    // Bytes carried by one bus word (four 8-bit pixels).
    localparam int WORD_BYTES = 4;

    // Number of cycles the frame-done interrupt stays high.
    localparam int INT_CYCLES = 4;

    // Bytes in one frame at 8 bits per pixel.
    function automatic int frame_bytes(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/video_out_load.sv
// Wishbone read master that streams one frame from RAM into the pixel FIFO.
// Each word read is one 32-bit FIFO entry; bursts start only when the FIFO
// reports room for a whole burst.
//
// Handshake: a bus beat opens with CYC=STB=1 and holds address and controls
// until ACK or ERR is sampled high at a rising edge; that edge drops STB and
// produces exactly one fifo_write cycle. ERR wins over ACK and writes a zero
// word. There is no FIFO back-pressure beyond fifo_room, checked per burst.
module video_out_load
    import video_out_pkg::*;
#(
    parameter int p_WIDTH     = 640,
    parameter int p_HEIGHT    = 480,
    parameter int BURST_WORDS = 16
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] wb_reg_ctr,
    input  logic [31:0] wb_reg_data,
    input  logic        fifo_room,
    output logic [31:0] fifo_wdata,
    output logic        fifo_write,
    output logic        new_addr,
    output logic        interrupt,
    output logic        err_flag,
    output logic        p_wb_CYC_O,
    output logic        p_wb_STB_O,
    output logic        p_wb_LOCK_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic [31:0] p_wb_DAT_I,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I
);

    localparam int              CNT_W      = $clog2(BURST_WORDS + 1);
    localparam logic [19:0]     FRAME_OFF  = 20'(frame_bytes(p_WIDTH, p_HEIGHT));
    localparam logic [19:0]     WORD_STEP  = 20'(WORD_BYTES);
    localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_WORDS);
    localparam logic [CNT_W-1:0] ONE_BEAT   = CNT_W'(1);
    localparam logic [1:0]      INT_LAST   = 2'(INT_CYCLES - 1);

    state_t           state;
    logic             old_ctr0;
    logic [31:0]      base;
    logic [19:0]      offset;
    logic [CNT_W-1:0] burst_cnt;
    logic [1:0]       int_cnt;

    logic [19:0]      next_offset;
    logic [19:0]      rem_bytes;
    logic [17:0]      words_left;
    logic [CNT_W-1:0] burst_load;
    logic             unused_bits;

    // Control bits above bit 0 and the byte lane of the base are not used.
    assign unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};

    assign new_addr   = wb_reg_ctr[0] & ~old_ctr0;
    assign p_wb_WE_O  = 1'b0;
    assign p_wb_SEL_O = 4'hf;

    // Burst length for the next request: a full burst, or what is left of the frame.
    always_comb begin
        next_offset = offset + WORD_STEP;
        rem_bytes   = FRAME_OFF - offset;
        words_left  = rem_bytes[19:2];
        burst_load  = BURST_LOAD;
        if (words_left < 18'(BURST_WORDS)) begin
            burst_load = words_left[CNT_W-1:0];
        end
    end

    // Previous value of the start bit, for rising-edge detection.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            old_ctr0 <= 1'b0;
        end else begin
            old_ctr0 <= wb_reg_ctr[0];
        end
    end

    // Frame fetch sequencer with registered bus, FIFO and interrupt outputs.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= WAIT_ADDR;
            base        <= '0;
            offset      <= '0;
            burst_cnt   <= '0;
            int_cnt     <= '0;
            p_wb_CYC_O  <= 1'b0;
            p_wb_STB_O  <= 1'b0;
            p_wb_LOCK_O <= 1'b0;
            p_wb_ADR_O  <= '0;
            fifo_wdata  <= '0;
            fifo_write  <= 1'b0;
            interrupt   <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            fifo_write <= 1'b0;
            case (state)
                WAIT_ADDR: begin
                    if (new_addr) begin
                        base     <= {wb_reg_data[31:2], 2'b00};
                        offset   <= '0;
                        err_flag <= 1'b0;
                        state    <= WAIT_ROOM;
                    end
                end
                WAIT_ROOM: begin
                    if (fifo_room) begin
                        burst_cnt <= burst_load;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    p_wb_ADR_O  <= base + {12'h000, offset};
                    p_wb_CYC_O  <= 1'b1;
                    p_wb_STB_O  <= 1'b1;
                    p_wb_LOCK_O <= 1'b1;
                    state       <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (p_wb_ACK_I || p_wb_ERR_I) begin
                        p_wb_STB_O <= 1'b0;
                        fifo_write <= 1'b1;
                        fifo_wdata <= p_wb_ERR_I ? 32'h0 : p_wb_DAT_I;
                        if (p_wb_ERR_I) begin
                            err_flag <= 1'b1;
                        end
                        offset    <= next_offset;
                        burst_cnt <= burst_cnt - ONE_BEAT;
                        if (next_offset == FRAME_OFF) begin
                            p_wb_CYC_O  <= 1'b0;
                            p_wb_LOCK_O <= 1'b0;
                            interrupt   <= 1'b1;
                            int_cnt     <= '0;
                            state       <= FRAME_DONE;
                        end else if (burst_cnt == ONE_BEAT) begin
                            p_wb_CYC_O  <= 1'b0;
                            p_wb_LOCK_O <= 1'b0;
                            state       <= WAIT_ROOM;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                FRAME_DONE: begin
                    if (int_cnt == INT_LAST) begin
                        interrupt <= 1'b0;
                        offset    <= '0;
                        state     <= WAIT_ADDR;
                    end else begin
                        int_cnt <= int_cnt + 2'd1;
                    end
                end
                default: state <= WAIT_ADDR;
            endcase
        end
    end

endmodule

// File: tb/tb_video_out_load.sv
// Self-checking bench for video_out_load: small frame (8x2 pixels, 4 words,
// bursts of 2), randomized slave wait states and data.
module tb_video_out_load;

    localparam int W           = 8;
    localparam int H           = 2;
    localparam int BW          = 2;
    localparam int FRAME_WORDS = W * H / 4;

    logic        clk;
    logic        nRST;
    logic [31:0] wb_reg_ctr;
    logic [31:0] wb_reg_data;
    logic        fifo_room;
    logic [31:0] fifo_wdata;
    logic        fifo_write;
    logic        new_addr;
    logic        interrupt;
    logic        err_flag;
    logic        p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O;
    logic [3:0]  p_wb_SEL_O;
    logic [31:0] p_wb_ADR_O;
    logic [31:0] p_wb_DAT_I;
    logic        p_wb_ACK_I, p_wb_ERR_I;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard and observation queues.
    logic [31:0] exp_q[$];
    logic [31:0] obs_data[$];
    logic [31:0] obs_adr[$];
    int          obs_burst[$];
    int          obs_int[$];
    int          proto_err = 0;

    // Slave configuration.
    int fixed_wait = 1;
    int cur_wait   = 0;
    int err_beat   = -1;
    int beat_idx   = 0;
    bit use_table  = 1'b0;

    video_out_load #(
        .p_WIDTH(W), .p_HEIGHT(H), .BURST_WORDS(BW)
    ) dut (
        .clk(clk), .nRST(nRST),
        .wb_reg_ctr(wb_reg_ctr), .wb_reg_data(wb_reg_data),
        .fifo_room(fifo_room), .fifo_wdata(fifo_wdata), .fifo_write(fifo_write),
        .new_addr(new_addr), .interrupt(interrupt), .err_flag(err_flag),
        .p_wb_CYC_O(p_wb_CYC_O), .p_wb_STB_O(p_wb_STB_O), .p_wb_LOCK_O(p_wb_LOCK_O),
        .p_wb_WE_O(p_wb_WE_O), .p_wb_SEL_O(p_wb_SEL_O), .p_wb_ADR_O(p_wb_ADR_O),
        .p_wb_DAT_I(p_wb_DAT_I), .p_wb_ACK_I(p_wb_ACK_I), .p_wb_ERR_I(p_wb_ERR_I)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wishbone slave: answers each STB after cur_wait wait states.
    initial begin
        logic [31:0] d;
        int wcnt;
        wcnt = 0;
        p_wb_ACK_I = 1'b0;
        p_wb_ERR_I = 1'b0;
        p_wb_DAT_I = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!p_wb_STB_O || p_wb_ACK_I || p_wb_ERR_I) begin
                p_wb_ACK_I = 1'b0;
                p_wb_ERR_I = 1'b0;
                wcnt = 0;
            end else if (wcnt >= cur_wait) begin
                d = use_table ? (32'hA0 + 32'(beat_idx)) : $urandom;
                p_wb_DAT_I = d;
                p_wb_ACK_I = 1'b1;
                p_wb_ERR_I = (beat_idx == err_beat);
                exp_q.push_back((beat_idx == err_beat) ? 32'h0 : d);
                beat_idx++;
                cur_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end else begin
                wcnt++;
            end
        end
    end

    // Bus/FIFO monitor: records beats, writes, burst lengths, interrupt widths.
    initial begin
        logic stb_prev, cyc_prev;
        int gap, beats, int_run;
        stb_prev = 0; cyc_prev = 0; gap = 0; beats = 0; int_run = 0;
        forever begin
            @(negedge clk);
            if (nRST) begin
                if (p_wb_STB_O && !p_wb_CYC_O) proto_err++;
                if (p_wb_WE_O !== 1'b0 || p_wb_SEL_O !== 4'hf) proto_err++;
                if (fifo_write !== (p_wb_ACK_I | p_wb_ERR_I)) proto_err++;
                if (p_wb_STB_O && !stb_prev) begin
                    obs_adr.push_back(p_wb_ADR_O);
                    beats++;
                    if (cyc_prev && gap != 1) proto_err++;
                end
                if (p_wb_CYC_O && !p_wb_STB_O) gap++;
                else gap = 0;
                if (cyc_prev && !p_wb_CYC_O) begin
                    obs_burst.push_back(beats);
                    beats = 0;
                end
                if (fifo_write) obs_data.push_back(fifo_wdata);
                if (interrupt) int_run++;
                else if (int_run != 0) begin
                    obs_int.push_back(int_run);
                    int_run = 0;
                end
            end else begin
                gap = 0; beats = 0; int_run = 0;
            end
            stb_prev = p_wb_STB_O;
            cyc_prev = p_wb_CYC_O;
        end
    end

    // Driver: program a base address and raise the start bit.
    task automatic start_frame(input logic [31:0] base, output logic na_now, output logic na_next);
        @(negedge clk);
        wb_reg_ctr[0] = 1'b0;
        wb_reg_data   = base;
        exp_q.delete(); obs_data.delete(); obs_adr.delete();
        obs_burst.delete(); obs_int.delete();
        proto_err = 0;
        beat_idx  = 0;
        cur_wait  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        @(negedge clk);
        wb_reg_ctr[0] = 1'b1;
        #1 na_now = new_addr;
        @(negedge clk);
        #1 na_next = new_addr;
    endtask

    // Wait (bounded) for the interrupt pulse to finish.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (obs_int.size() == 0 && n < 400) begin
            @(negedge clk);
            #2;
            n++;
        end
        n_checks++;
        if (obs_int.size() == 0) begin
            n_fail++;
            $display("FAIL %s_done: no interrupt after %0d cycles, expected one", name, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        wb_reg_ctr = '0; wb_reg_data = '0; fifo_room = 1'b1;
        #2;
        n_checks += 6;
        if (p_wb_CYC_O !== 0 || p_wb_STB_O !== 0 || p_wb_LOCK_O !== 0) begin
            n_fail++; $display("FAIL reset_bus_ctl: cyc/stb/lock=%b%b%b expected 000", p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O);
        end
        if (p_wb_SEL_O !== 4'hf || p_wb_WE_O !== 1'b0) begin
            n_fail++; $display("FAIL reset_sel_we: sel=%h we=%b expected f/0", p_wb_SEL_O, p_wb_WE_O);
        end
        if (p_wb_ADR_O !== 32'h0) begin
            n_fail++; $display("FAIL reset_adr: got %h expected 0", p_wb_ADR_O);
        end
        if (fifo_write !== 1'b0 || fifo_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_fifo: write=%b data=%h expected 0/0", fifo_write, fifo_wdata);
        end
        if (interrupt !== 1'b0 || err_flag !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: int=%b err=%b expected 0/0", interrupt, err_flag);
        end
        if (new_addr !== 1'b0) begin
            n_fail++; $display("FAIL reset_new_addr: got %b expected 0", new_addr);
        end
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame;
        logic na_now, na_next;
        int rem, b, k;
        fixed_wait = 1; use_table = 1'b1; err_beat = -1; fifo_room = 1'b1;
        start_frame(32'h1000, na_now, na_next);
        n_checks += 2;
        if (na_now !== 1'b1) begin n_fail++; $display("FAIL basic_new_addr_hi: got %b expected 1", na_now); end
        if (na_next !== 1'b0) begin n_fail++; $display("FAIL basic_new_addr_lo: got %b expected 0", na_next); end
        wait_done("basic");
        n_checks += 2;
        if (obs_adr.size() != FRAME_WORDS) begin n_fail++; $display("FAIL basic_nbeats: got %0d expected %0d", obs_adr.size(), FRAME_WORDS); end
        if (obs_data.size() != FRAME_WORDS) begin n_fail++; $display("FAIL basic_nwrites: got %0d expected %0d", obs_data.size(), FRAME_WORDS); end
        for (int i = 0; i < FRAME_WORDS && i < obs_adr.size() && i < obs_data.size(); i++) begin
            n_checks += 2;
            if (obs_adr[i] !== 32'h1000 + 32'(4 * i)) begin
                n_fail++; $display("FAIL basic_adr%0d: got %h expected %h", i, obs_adr[i], 32'h1000 + 32'(4 * i));
            end
            if (obs_data[i] !== 32'hA0 + 32'(i)) begin
                n_fail++; $display("FAIL basic_data%0d: got %h expected %h", i, obs_data[i], 32'hA0 + 32'(i));
            end
        end
        rem = FRAME_WORDS; k = 0;
        while (rem > 0) begin
            b = (rem < BW) ? rem : BW;
            n_checks++;
            if (k >= obs_burst.size() || obs_burst[k] != b) begin
                n_fail++; $display("FAIL basic_burst%0d: got %0d expected %0d", k, (k < obs_burst.size()) ? obs_burst[k] : -1, b);
            end
            rem -= b; k++;
        end
        n_checks += 3;
        if (obs_int.size() != 1 || obs_int[0] != 4) begin
            n_fail++; $display("FAIL basic_int_len: got %0d expected 4", (obs_int.size() > 0) ? obs_int[0] : -1);
        end
        if (proto_err != 0) begin n_fail++; $display("FAIL basic_protocol: got %0d violations expected 0", proto_err); end
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL basic_err_flag: got %b expected 0", err_flag); end
    endtask

    task automatic test_room_stall;
        logic na_now, na_next, saw, act;
        int n;
        fixed_wait = -1; use_table = 1'b0; err_beat = -1; fifo_room = 1'b1;
        start_frame(32'h4000, na_now, na_next);
        n = 0;
        while (!p_wb_STB_O && n < 50) begin @(negedge clk); #2; n++; end
        fifo_room = 1'b0;
        saw = 1'b1; n = 0;
        while (saw && n < 100) begin
            @(negedge clk); #2; n++;
            if (!p_wb_CYC_O) saw = 1'b0;
        end
        act = 1'b0;
        repeat (10) begin
            @(negedge clk); #2;
            if (p_wb_CYC_O || p_wb_STB_O) act = 1'b1;
        end
        n_checks++;
        if (act !== 1'b0) begin n_fail++; $display("FAIL stall_idle: bus activity %b expected 0", act); end
        @(negedge clk);
        fifo_room = 1'b1;
        @(negedge clk); #2;
        n_checks++;
        if (p_wb_STB_O !== 1'b0) begin n_fail++; $display("FAIL stall_req_cycle: stb=%b expected 0", p_wb_STB_O); end
        @(negedge clk); #2;
        n_checks += 2;
        if (p_wb_STB_O !== 1'b1) begin n_fail++; $display("FAIL stall_resume_stb: stb=%b expected 1", p_wb_STB_O); end
        if (p_wb_ADR_O !== 32'h4008) begin n_fail++; $display("FAIL stall_resume_adr: got %h expected 4008", p_wb_ADR_O); end
        wait_done("stall");
        n_checks += 2;
        if (obs_data.size() != exp_q.size() || obs_data.size() != FRAME_WORDS) begin
            n_fail++; $display("FAIL stall_nwrites: got %0d expected %0d", obs_data.size(), FRAME_WORDS);
        end
        if (proto_err != 0) begin n_fail++; $display("FAIL stall_protocol: got %0d violations expected 0", proto_err); end
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_data%0d: got %h expected %h", i, obs_data[i], exp_q[i]); end
        end
    endtask

    task automatic test_bus_error;
        logic na_now, na_next;
        fixed_wait = -1; use_table = 1'b0; err_beat = 2; fifo_room = 1'b1;
        start_frame(32'h6000, na_now, na_next);
        wait_done("err");
        err_beat = -1;
        n_checks += 4;
        if (obs_data.size() != FRAME_WORDS) begin n_fail++; $display("FAIL err_nwrites: got %0d expected %0d", obs_data.size(), FRAME_WORDS); end
        if (obs_data.size() > 2 && obs_data[2] !== 32'h0) begin n_fail++; $display("FAIL err_zero_word: got %h expected 0", obs_data[2]); end
        if (err_flag !== 1'b1) begin n_fail++; $display("FAIL err_flag_set: got %b expected 1", err_flag); end
        if (obs_int.size() != 1 || obs_int[0] != 4) begin n_fail++; $display("FAIL err_int_len: got %0d expected 4", (obs_int.size() > 0) ? obs_int[0] : -1); end
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL err_data%0d: got %h expected %h", i, obs_data[i], exp_q[i]); end
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err_flag !== 1'b1) begin n_fail++; $display("FAIL err_flag_sticky: got %b expected 1", err_flag); end
    endtask

    task automatic test_unaligned;
        logic na_now, na_next;
        fixed_wait = -1; use_table = 1'b0; err_beat = -1; fifo_room = 1'b1;
        start_frame(32'h2003, na_now, na_next);
        n_checks++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL unal_err_clear: got %b expected 0", err_flag); end
        wait_done("unal");
        n_checks++;
        if (obs_adr.size() != FRAME_WORDS) begin n_fail++; $display("FAIL unal_nbeats: got %0d expected %0d", obs_adr.size(), FRAME_WORDS); end
        for (int i = 0; i < obs_adr.size(); i++) begin
            n_checks++;
            if (obs_adr[i] !== (32'h2003 & ~32'h3) + 32'(4 * i)) begin
                n_fail++; $display("FAIL unal_adr%0d: got %h expected %h", i, obs_adr[i], (32'h2003 & ~32'h3) + 32'(4 * i));
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        logic na_now, na_next, act;
        int n;
        fixed_wait = 3; use_table = 1'b0; err_beat = -1; fifo_room = 1'b1;
        start_frame(32'h7000, na_now, na_next);
        n = 0;
        while (obs_adr.size() < 2 && n < 200) begin @(negedge clk); #2; n++; end
        n_checks++;
        if (obs_adr.size() < 2) begin n_fail++; $display("FAIL rst_mid_reach: beats %0d expected 2", obs_adr.size()); end
        nRST = 1'b0;
        wb_reg_ctr[0] = 1'b0;
        #1;
        n_checks += 2;
        if (p_wb_CYC_O !== 0 || p_wb_STB_O !== 0 || p_wb_LOCK_O !== 0) begin
            n_fail++; $display("FAIL rst_mid_bus: cyc/stb/lock=%b%b%b expected 000", p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O);
        end
        if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL rst_mid_write: got %b expected 0", fifo_write); end
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        act = 1'b0;
        repeat (20) begin
            @(negedge clk); #2;
            if (p_wb_CYC_O || p_wb_STB_O || fifo_write) act = 1'b1;
        end
        n_checks++;
        if (act !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: activity %b expected 0", act); end
        fixed_wait = -1;
        start_frame(32'h7000, na_now, na_next);
        wait_done("rst_restart");
        n_checks++;
        if (obs_adr.size() != FRAME_WORDS) begin n_fail++; $display("FAIL rst_restart_nbeats: got %0d expected %0d", obs_adr.size(), FRAME_WORDS); end
        for (int i = 0; i < obs_adr.size(); i++) begin
            n_checks++;
            if (obs_adr[i] !== 32'h7000 + 32'(4 * i)) begin
                n_fail++; $display("FAIL rst_restart_adr%0d: got %h expected %h", i, obs_adr[i], 32'h7000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_mid_frame_toggle;
        logic na_now, na_next;
        int n;
        fixed_wait = -1; use_table = 1'b0; err_beat = -1; fifo_room = 1'b1;
        start_frame(32'h3000, na_now, na_next);
        n = 0;
        while (obs_data.size() < 1 && n < 100) begin @(negedge clk); #2; n++; end
        @(negedge clk);
        wb_reg_data   = 32'h5000;
        wb_reg_ctr[0] = 1'b0;
        @(negedge clk);
        wb_reg_ctr[0] = 1'b1;
        #1;
        n_checks++;
        if (new_addr !== 1'b1) begin n_fail++; $display("FAIL toggle_new_addr_hi: got %b expected 1", new_addr); end
        @(negedge clk); #1;
        n_checks++;
        if (new_addr !== 1'b0) begin n_fail++; $display("FAIL toggle_new_addr_lo: got %b expected 0", new_addr); end
        wait_done("toggle");
        n_checks++;
        if (obs_adr.size() != FRAME_WORDS) begin n_fail++; $display("FAIL toggle_nbeats: got %0d expected %0d", obs_adr.size(), FRAME_WORDS); end
        for (int i = 0; i < obs_adr.size(); i++) begin
            n_checks++;
            if (obs_adr[i] !== 32'h3000 + 32'(4 * i)) begin
                n_fail++; $display("FAIL toggle_adr%0d: got %h expected %h", i, obs_adr[i], 32'h3000 + 32'(4 * i));
            end
        end
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle_data%0d: got %h expected %h", i, obs_data[i], exp_q[i]); end
        end
        repeat (20) @(negedge clk);
        n_checks += 2;
        if (obs_adr.size() != FRAME_WORDS) begin n_fail++; $display("FAIL toggle_no_restart: beats %0d expected %0d", obs_adr.size(), FRAME_WORDS); end
        if (proto_err != 0) begin n_fail++; $display("FAIL toggle_protocol: got %0d violations expected 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_room_stall();
        test_bus_error();
        test_unaligned();
        test_reset_mid_burst();
        test_mid_frame_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
